// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer: FSM states, opcode classes,
// flag-select codes and ALU function codes.
package seq_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        IMM    = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } state_t;

    // Opcode classes, taken from ir[7:5]
    localparam logic [2:0] CLS_NOP  = 3'b000;
    localparam logic [2:0] CLS_ALUI = 3'b001;
    localparam logic [2:0] CLS_CLC  = 3'b010;
    localparam logic [2:0] CLS_JMP  = 3'b011;
    localparam logic [2:0] CLS_JCC  = 3'b100;
    localparam logic [2:0] CLS_ILL5 = 3'b101;
    localparam logic [2:0] CLS_ILL6 = 3'b110;
    localparam logic [2:0] CLS_HALT = 3'b111;

    // Flag selects for conditional jumps, taken from ir[2:0]
    localparam logic [2:0] FLG_C  = 3'd0;
    localparam logic [2:0] FLG_OV = 3'd1;
    localparam logic [2:0] FLG_P  = 3'd2;
    localparam logic [2:0] FLG_Z  = 3'd3;
    localparam logic [2:0] FLG_S  = 3'd4;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd4;
    localparam logic [2:0] ALU_SUB  = 3'd5;

    function automatic logic needs_imm(input logic [2:0] cls);
        return (cls == CLS_ALUI) || (cls == CLS_JMP) || (cls == CLS_JCC);
    endfunction

    function automatic logic is_illegal(input logic [2:0] cls);
        return (cls == CLS_ILL5) || (cls == CLS_ILL6);
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Conditional-jump evaluation: selects one of the five datapath flags and optionally inverts it.
// Selects outside the flag range evaluate as false before inversion.
module branch_cond
    import seq_pkg::*;
(
    input  logic       c,
    input  logic       ov,
    input  logic       p,
    input  logic       z,
    input  logic       s,
    input  logic [2:0] sel,
    input  logic       inv,
    output logic       take
);

    logic cond;

    always_comb begin
        cond = 1'b0;
        case (sel)
            FLG_C:   cond = c;
            FLG_OV:  cond = ov;
            FLG_P:   cond = p;
            FLG_Z:   cond = z;
            FLG_S:   cond = s;
            default: cond = 1'b0;
        endcase
        take = cond ^ inv;
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer driving the ALU/accumulator/flag datapath from program ROM.
// Optional feature ILLEGAL_TRAP_EN: adds an 'illegal' output and traps classes 101/110 into HALTED.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              C,
    input  logic              OV,
    input  logic              P,
    input  logic              Z,
    input  logic              S,
    output logic [PC_W-1:0]   pc,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] b,
    output logic              A_ce,
    output logic              C_OV_en,
    output logic              C_OV_kasowanie,
`ifdef ILLEGAL_TRAP_EN
    output logic              illegal,
`endif
    output logic              halt
);

    localparam int CW = (PC_W < DATA_W) ? PC_W : DATA_W;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] imm_q, imm_d;

    logic [2:0]        cls;
    logic              take;
    logic [PC_W-1:0]   target;
    logic              ir_unused;

    assign cls       = ir_q[7:5];
    assign ir_unused = ir_q[4];
    assign target    = PC_W'(imm_q[CW-1:0]);

    branch_cond u_branch_cond (
        .c    (C),
        .ov   (OV),
        .p    (P),
        .z    (Z),
        .s    (S),
        .sel  (ir_q[2:0]),
        .inv  (ir_q[3]),
        .take (take)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        imm_d   = imm_q;
        case (state_q)
            FETCH: begin
                ir_d    = rom_data;
                pc_d    = pc_q + PC_W'(1);
                state_d = needs_imm(rom_data[7:5]) ? IMM : EXEC;
            end
            IMM: begin
                imm_d   = rom_data;
                pc_d    = pc_q + PC_W'(1);
                state_d = EXEC;
            end
            EXEC: begin
                // Flags are sampled here; pc already points past the immediate if not taken
                if ((cls == CLS_JMP) || ((cls == CLS_JCC) && take)) begin
                    pc_d = target;
                end
                state_d = FETCH;
                if (cls == CLS_HALT) begin
                    state_d = HALTED;
                end
`ifdef ILLEGAL_TRAP_EN
                if (is_illegal(cls)) begin
                    state_d = HALTED;
                end
`endif
            end
            default: begin
                state_d = HALTED;
            end
        endcase
    end

    // Strobes are purely combinational from state/ir so async reset drops them at once
    always_comb begin
        A_ce           = 1'b0;
        C_OV_en        = 1'b0;
        C_OV_kasowanie = 1'b0;
        if (state_q == EXEC) begin
            if (cls == CLS_ALUI) begin
                A_ce    = 1'b1;
                C_OV_en = ir_q[3];
            end
            if (cls == CLS_CLC) begin
                C_OV_kasowanie = 1'b1;
            end
        end
    end

    assign pc     = pc_q;
    assign alu_op = ir_q[2:0];
    assign b      = imm_q;
    assign halt   = (state_q == HALTED);

`ifdef ILLEGAL_TRAP_EN
    // ir is frozen in HALTED, so the trapping class remains visible until reset
    assign illegal = (state_q == HALTED) && is_illegal(cls);
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized programs checked
// against an instruction-level reference model.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rom_data;
    logic       C = 1'b0, OV = 1'b0, P = 1'b0, Z = 1'b0, S = 1'b0;
    logic [7:0] pc;
    logic [2:0] alu_op;
    logic [7:0] b;
    logic       A_ce, C_OV_en, C_OV_kasowanie, halt;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    logic [7:0] rom [256];
    logic [7:0] mpc;
    logic [7:0] mimm;
    int         n_chk = 0;
    int         n_fail = 0;

    assign rom_data = rom[pc];

    always #5 clk = ~clk;

    instr_sequencer #(.PC_W(8), .DATA_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_data       (rom_data),
        .C              (C),
        .OV             (OV),
        .P              (P),
        .Z              (Z),
        .S              (S),
        .pc             (pc),
        .alu_op         (alu_op),
        .b              (b),
        .A_ce           (A_ce),
        .C_OV_en        (C_OV_en),
        .C_OV_kasowanie (C_OV_kasowanie),
`ifdef ILLEGAL_TRAP_EN
        .illegal        (illegal),
`endif
        .halt           (halt)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic set_flags(input logic c, input logic ov, input logic p, input logic z, input logic s);
        C = c; OV = ov; P = p; Z = z; S = s;
    endtask

    function automatic logic flag_of(input logic [2:0] sel);
        case (sel)
            3'd0:    return C;
            3'd1:    return OV;
            3'd2:    return P;
            3'd3:    return Z;
            3'd4:    return S;
            default: return 1'b0;
        endcase
    endfunction

    // Assert reset mid-cycle, check cleared outputs, release before the first fetch edge
    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_pc",   32'(pc), 32'h0);
        chk("rst_ace",  32'(A_ce), 32'h0);
        chk("rst_en",   32'(C_OV_en), 32'h0);
        chk("rst_kas",  32'(C_OV_kasowanie), 32'h0);
        chk("rst_halt", 32'(halt), 32'h0);
        chk("rst_b",    32'(b), 32'h0);
        chk("rst_op",   32'(alu_op), 32'h0);
`ifdef ILLEGAL_TRAP_EN
        chk("rst_ill",  32'(illegal), 32'h0);
`endif
        @(negedge clk);
        rst  = 1'b0;
        mpc  = 8'h00;
        mimm = 8'h00;
    endtask

    // Reference: one whole instruction, checking every cycle of it. Returns 1 if it halts.
    task automatic step_instr(output bit halted);
        logic [7:0] op;
        logic [2:0] cls;
        bit         two, take, ill;
        op  = rom[mpc];
        cls = op[7:5];
        two = (cls == 3'd1) || (cls == 3'd3) || (cls == 3'd4);
`ifdef ILLEGAL_TRAP_EN
        ill = (cls == 3'd5) || (cls == 3'd6);
`else
        ill = 1'b0;
`endif
        chk("fetch_pc",   32'(pc), 32'(mpc));
        chk("fetch_ace",  32'(A_ce | C_OV_en | C_OV_kasowanie), 32'h0);
        chk("fetch_halt", 32'(halt), 32'h0);
        chk("fetch_b",    32'(b), 32'(mimm));
        tick();
        mpc = mpc + 8'd1;
        if (two) begin
            chk("imm_pc",  32'(pc), 32'(mpc));
            chk("imm_ace", 32'(A_ce | C_OV_en | C_OV_kasowanie), 32'h0);
            mimm = rom[mpc];
            tick();
            mpc = mpc + 8'd1;
        end
        chk("exec_op",   32'(alu_op), 32'(op[2:0]));
        chk("exec_b",    32'(b), 32'(mimm));
        chk("exec_ace",  32'(A_ce), 32'(cls == 3'd1));
        chk("exec_en",   32'(C_OV_en), 32'((cls == 3'd1) && op[3]));
        chk("exec_kas",  32'(C_OV_kasowanie), 32'(cls == 3'd2));
        chk("exec_halt", 32'(halt), 32'h0);
        take = (cls == 3'd3) || ((cls == 3'd4) && (flag_of(op[2:0]) ^ op[3]));
        tick();
        if (take) mpc = mimm;
        halted = (cls == 3'd7) || ill;
    endtask

    initial begin
        bit h;
        logic [7:0] v;
        clear_rom();
        #2;
        do_reset();

        // ALUI without and with C/OV update
        clear_rom();
        rom[0] = 8'h20; rom[1] = 8'h05; rom[2] = 8'h2C; rom[3] = 8'h04;
        do_reset();
        step_instr(h);
        step_instr(h);
        chk("alui_pc_after", 32'(pc), 32'h04);

        // Conditional jumps on Z, plain and inverted
        clear_rom();
        rom[0] = 8'h83; rom[1] = 8'h10;
        set_flags(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_reset();
        step_instr(h);
        chk("jz_taken", 32'(pc), 32'h10);
        set_flags(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        do_reset();
        step_instr(h);
        chk("jz_not_taken", 32'(pc), 32'h02);
        rom[0] = 8'h8B;
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        step_instr(h);
        chk("jnz_taken", 32'(pc), 32'h10);

        // CLC
        clear_rom();
        rom[0] = 8'h40;
        do_reset();
        step_instr(h);
        chk("clc_pc", 32'(pc), 32'h01);
        chk("clc_kas_after", 32'(C_OV_kasowanie), 32'h0);

        // pc wrap: NOP at FF, then JMP at FF with its immediate at 00
        clear_rom();
        rom[0] = 8'h60; rom[1] = 8'hFF;
        do_reset();
        step_instr(h);
        chk("jmp_ff", 32'(pc), 32'hFF);
        step_instr(h);
        chk("wrap_nop", 32'(pc), 32'h00);
        rom[8'hFF] = 8'h60;
        do_reset();
        step_instr(h);
        step_instr(h);
        chk("wrap_jmp", 32'(pc), 32'h60);

        // Reset during EXEC of an ALUI with C/OV update
        clear_rom();
        rom[0] = 8'h2C; rom[1] = 8'h04;
        do_reset();
        tick();
        tick();
        chk("pre_rst_ace", 32'(A_ce), 32'h1);
        chk("pre_rst_en",  32'(C_OV_en), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ace", 32'(A_ce), 32'h0);
        chk("mid_rst_en",  32'(C_OV_en), 32'h0);
        chk("mid_rst_pc",  32'(pc), 32'h0);
        @(negedge clk);
        rst  = 1'b0;
        mpc  = 8'h00;
        mimm = 8'h00;
        step_instr(h);
        chk("post_rst_pc", 32'(pc), 32'h02);

        // HALT
        clear_rom();
        rom[0] = 8'hE0;
        do_reset();
        step_instr(h);
        for (int i = 0; i < 20; i++) begin
            chk("halt_flag", 32'(halt), 32'h1);
            chk("halt_pc",   32'(pc), 32'(mpc));
            chk("halt_strb", 32'(A_ce | C_OV_en | C_OV_kasowanie), 32'h0);
            tick();
        end

        // Illegal class
        clear_rom();
        rom[0] = 8'hA0;
        do_reset();
        step_instr(h);
`ifdef ILLEGAL_TRAP_EN
        chk("ill_halt", 32'(halt), 32'h1);
        chk("ill_flag", 32'(illegal), 32'h1);
        tick();
        chk("ill_hold", 32'(illegal & halt), 32'h1);
`else
        chk("ill_nop_pc",   32'(pc), 32'h01);
        chk("ill_nop_halt", 32'(halt), 32'h0);
`endif

        // Randomized programs with random flags
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            if (v[7:5] == 3'b111) v[7:5] = 3'b001;
`ifdef ILLEGAL_TRAP_EN
            if (v[7:5] == 3'b101 || v[7:5] == 3'b110) v[7:5] = 3'b100;
`endif
            rom[i] = v;
        end
        do_reset();
        for (int k = 0; k < 300; k++) begin
            set_flags(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            step_instr(h);
            if (h) break;
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
